branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_btb.sv | 38 +++
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor.
//   PHT_IDX_W   : gshare index / global history width
//   BTB_ENTRIES : direct-mapped BTB depth (power of two)
//   btb_entry_t : one BTB line {valid, tag, target, uncond}
//   CNT_INIT    : PHT counter value after reset (weakly not-taken)
//   cnt_next    : 2-bit saturating counter step
package bp_pkg;

    localparam int unsigned PHT_IDX_W   = 8;
    localparam int unsigned BTB_ENTRIES = 64;
    localparam int unsigned BTB_TAG_W   = 24;
    localparam logic [1:0]  CNT_INIT    = 2'b01;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic                 uncond;
    } btb_entry_t;

    // Saturating step: 2'b11 and 2'b00 hold at their limits.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && cnt != 2'b11) begin
            res = cnt + 2'd1;
        end else if (!up && cnt != 2'b00) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer storage.
//   clk, rst  : clock, synchronous active-high clear of all valid bits
//   rd_idx    : combinational read index
//   rd_entry  : entry at rd_idx (reflects writes only after the edge)
//   wr_en     : write strobe
//   wr_idx    : write index
//   wr_entry  : entry written on the rising edge
module bp_btb
    import bp_pkg::*;
#(
    parameter  int unsigned ENTRIES = BTB_ENTRIES,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    btb_entry_t mem [ENTRIES];

    // Storage update; reset only needs to drop the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB.
//   clk, rst          : clock, synchronous active-high reset
//   F_*               : fetch-side lookup (combinational from registered state)
//   E_*  (inputs)     : EX-stage resolution of a branch / JAL and the
//                       prediction data carried down with it
//   E_redirect(_pc)   : misprediction flag and correct next PC
module branch_predictor #(
    parameter int unsigned PHT_IDX_W   = bp_pkg::PHT_IDX_W,
    parameter int unsigned BTB_ENTRIES = bp_pkg::BTB_ENTRIES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          F_PC,
    output logic                 F_pred_taken,
    output logic [PHT_IDX_W-1:0] F_pht_idx,
    output logic                 F_btb_hit,
    output logic [31:0]          F_btb_target,
    output logic [31:0]          F_next_pc,
    input  logic                 E_br_valid,
    input  logic                 E_jal_valid,
    input  logic [31:0]          E_PC,
    input  logic                 E_actual_taken,
    input  logic [31:0]          E_actual_target,
    input  logic                 E_pred_taken,
    input  logic [PHT_IDX_W-1:0] E_pht_idx,
    input  logic                 E_btb_hit,
    input  logic [31:0]          E_btb_target,
    output logic                 E_redirect,
    output logic [31:0]          E_redirect_pc
);

    import bp_pkg::*;

    localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_LSB   = BTB_IDX_W + 2;
    localparam int unsigned PHT_DEPTH = 2 ** PHT_IDX_W;

    logic [PHT_IDX_W-1:0] ghr;
    logic [1:0]           pht [PHT_DEPTH];

    btb_entry_t f_entry;
    btb_entry_t wr_entry;
    logic       btb_wr;
    logic       e_jal;
    logic       e_br;
    logic       e_taken;

    bp_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (F_PC[BTB_IDX_W+1:2]),
        .rd_entry (f_entry),
        .wr_en    (btb_wr),
        .wr_idx   (E_PC[BTB_IDX_W+1:2]),
        .wr_entry (wr_entry)
    );

    // Fetch lookup: no bypass of same-cycle updates.
    always_comb begin
        F_pht_idx    = F_PC[PHT_IDX_W+1:2] ^ ghr;
        F_btb_hit    = f_entry.valid && (f_entry.tag == BTB_TAG_W'(F_PC >> TAG_LSB));
        F_btb_target = F_btb_hit ? f_entry.target : 32'd0;
        F_pred_taken = F_btb_hit && (f_entry.uncond || pht[F_pht_idx][1]);
        F_next_pc    = F_pred_taken ? F_btb_target : F_PC + 32'd4;
    end

    // Resolution: JAL wins over a simultaneous (illegal) branch report.
    always_comb begin
        e_jal         = E_jal_valid;
        e_br          = E_br_valid && !E_jal_valid;
        e_taken       = e_jal || E_actual_taken;
        E_redirect    = (e_br || e_jal) &&
                        ((e_taken != E_pred_taken) ||
                         (e_taken && (!E_btb_hit || E_btb_target != E_actual_target)));
        E_redirect_pc = e_taken ? E_actual_target : E_PC + 32'd4;
        btb_wr        = e_jal || (e_br && E_actual_taken);
        wr_entry      = '{valid:  1'b1,
                          tag:    BTB_TAG_W'(E_PC >> TAG_LSB),
                          target: E_actual_target,
                          uncond: e_jal};
    end

    // Direction state: counters and global history train on branches only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
            for (int i = 0; i < int'(PHT_DEPTH); i++) begin
                pht[i] <= CNT_INIT;
            end
        end else if (e_br) begin
            pht[E_pht_idx] <= cnt_next(pht[E_pht_idx], E_actual_taken);
            ghr            <= {ghr[PHT_IDX_W-2:0], E_actual_taken};
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic compared against a behavioural predictor model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] F_PC;
    logic        F_pred_taken;
    logic [7:0]  F_pht_idx;
    logic        F_btb_hit;
    logic [31:0] F_btb_target;
    logic [31:0] F_next_pc;
    logic        E_br_valid;
    logic        E_jal_valid;
    logic [31:0] E_PC;
    logic        E_actual_taken;
    logic [31:0] E_actual_target;
    logic        E_pred_taken;
    logic [7:0]  E_pht_idx;
    logic        E_btb_hit;
    logic [31:0] E_btb_target;
    logic        E_redirect;
    logic [31:0] E_redirect_pc;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .F_PC            (F_PC),
        .F_pred_taken    (F_pred_taken),
        .F_pht_idx       (F_pht_idx),
        .F_btb_hit       (F_btb_hit),
        .F_btb_target    (F_btb_target),
        .F_next_pc       (F_next_pc),
        .E_br_valid      (E_br_valid),
        .E_jal_valid     (E_jal_valid),
        .E_PC            (E_PC),
        .E_actual_taken  (E_actual_taken),
        .E_actual_target (E_actual_target),
        .E_pred_taken    (E_pred_taken),
        .E_pht_idx       (E_pht_idx),
        .E_btb_hit       (E_btb_hit),
        .E_btb_target    (E_btb_target),
        .E_redirect      (E_redirect),
        .E_redirect_pc   (E_redirect_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: counters as plain integers 0..3, history as an int.
    int          m_pht [256];
    int          m_ghr;
    bit          m_vld [64];
    int unsigned m_tag [64];
    int unsigned m_tgt [64];
    bit          m_unc [64];

    logic [31:0] pool [8] = '{32'h100, 32'h104, 32'h1100, 32'h3104,
                              32'h200, 32'h40,  32'h7c,   32'h2200};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic int m_idx(input int unsigned pc);
        return ((pc / 4) % 256) ^ m_ghr;
    endfunction

    function automatic int m_bidx(input int unsigned pc);
        return (pc / 4) % 64;
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_vld[m_bidx(pc)] && (m_tag[m_bidx(pc)] == pc / 256);
    endfunction

    task automatic check_fetch();
        int unsigned pc;
        bit          hit;
        bit          pred;
        int unsigned tgt;
        pc   = F_PC;
        hit  = m_hit(pc);
        tgt  = hit ? m_tgt[m_bidx(pc)] : 0;
        pred = hit && (m_unc[m_bidx(pc)] || m_pht[m_idx(pc)] >= 2);
        check("f_pht_idx", 32'(F_pht_idx), m_idx(pc));
        check("f_btb_hit", 32'(F_btb_hit), 32'(hit));
        check("f_btb_target", F_btb_target, tgt);
        check("f_pred_taken", 32'(F_pred_taken), 32'(pred));
        check("f_next_pc", F_next_pc, pred ? tgt : pc + 4);
    endtask

    task automatic check_exec();
        bit taken;
        bit redir;
        if (E_br_valid || E_jal_valid) begin
            taken = E_jal_valid ? 1'b1 : E_actual_taken;
            redir = (taken != E_pred_taken) ||
                    (taken && (!E_btb_hit || E_btb_target != E_actual_target));
            check("e_redirect", 32'(E_redirect), 32'(redir));
            if (redir) begin
                check("e_redirect_pc", E_redirect_pc, taken ? E_actual_target : E_PC + 4);
            end
        end else begin
            check("e_redirect_idle", 32'(E_redirect), 32'd0);
        end
    endtask

    task automatic model_write_btb(input int unsigned pc, input int unsigned tgt, input bit unc);
        m_vld[m_bidx(pc)] = 1'b1;
        m_tag[m_bidx(pc)] = pc / 256;
        m_tgt[m_bidx(pc)] = tgt;
        m_unc[m_bidx(pc)] = unc;
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 256; i++) m_pht[i] = 1;
            for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
            m_ghr = 0;
        end else if (E_jal_valid) begin
            model_write_btb(E_PC, E_actual_target, 1'b1);
        end else if (E_br_valid) begin
            if (E_actual_taken) begin
                if (m_pht[E_pht_idx] < 3) m_pht[E_pht_idx]++;
                model_write_btb(E_PC, E_actual_target, 1'b0);
            end else if (m_pht[E_pht_idx] > 0) begin
                m_pht[E_pht_idx]--;
            end
            m_ghr = ((m_ghr * 2) + int'(E_actual_taken)) % 256;
        end
    endtask

    // Inputs are set at the falling edge; check, clock, advance the model.
    task automatic run_cycle(input bit chk);
        #1;
        if (chk) begin
            check_fetch();
            check_exec();
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic e_idle();
        E_br_valid      = 1'b0;
        E_jal_valid     = 1'b0;
        E_PC            = 32'h0;
        E_actual_taken  = 1'b0;
        E_actual_target = 32'h0;
        E_pred_taken    = 1'b0;
        E_pht_idx       = 8'h0;
        E_btb_hit       = 1'b0;
        E_btb_target    = 32'h0;
    endtask

    task automatic e_branch(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                            input bit pred, input logic [7:0] idx,
                            input bit hit, input logic [31:0] btgt);
        E_br_valid      = 1'b1;
        E_jal_valid     = 1'b0;
        E_PC            = pc;
        E_actual_taken  = tk;
        E_actual_target = tgt;
        E_pred_taken    = pred;
        E_pht_idx       = idx;
        E_btb_hit       = hit;
        E_btb_target    = btgt;
    endtask

    task automatic check_pht_all_init(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.pht[i] !== 2'b01) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int r;
        rst  = 1'b1;
        F_PC = 32'h100;
        e_idle();
        @(negedge clk);
        run_cycle(1'b0);
        run_cycle(1'b0);
        rst = 1'b0;

        // Reset state and first lookup.
        check_pht_all_init("reset_pht");
        check("reset_ghr", 32'(dut.ghr), 32'd0);
        F_PC = 32'h100;
        run_cycle(1'b1);
        check("reset_hit_const", 32'(F_btb_hit), 32'd0);
        check("reset_next_const", F_next_pc, 32'h104);

        // Mispredicted taken branch trains BTB and counter.
        e_branch(32'h100, 1'b1, 32'h180, 1'b0, 8'h40, 1'b0, 32'h0);
        #1;
        check("req22_redirect", 32'(E_redirect), 32'd1);
        check("req22_redirect_pc", E_redirect_pc, 32'h180);
        run_cycle(1'b1);
        e_idle();
        F_PC = 32'h100;
        #1;
        check("req22_hit", 32'(F_btb_hit), 32'd1);
        check("req22_target", F_btb_target, 32'h180);
        check("req22_cnt", 32'(dut.pht[8'h40]), 32'd2);
        run_cycle(1'b1);

        // Saturation high, then one step down.
        for (int k = 0; k < 4; k++) begin
            e_branch(32'h100, 1'b1, 32'h180, 1'b1, 8'h40, 1'b1, 32'h180);
            run_cycle(1'b1);
        end
        check("req23_sat", 32'(dut.pht[8'h40]), 32'(m_pht[8'h40]));
        check("req23_sat_const", 32'(dut.pht[8'h40]), 32'd3);
        e_branch(32'h100, 1'b0, 32'h180, 1'b1, 8'h40, 1'b1, 32'h180);
        run_cycle(1'b1);
        check("req23_dec", 32'(dut.pht[8'h40]), 32'd2);
        check("req23_predbit", 32'(dut.pht[8'h40][1]), 32'(m_pht[8'h40] >= 2));

        // JAL insertion leaves history untouched.
        e_idle();
        E_jal_valid     = 1'b1;
        E_PC            = 32'h200;
        E_actual_taken  = 1'b1;
        E_actual_target = 32'h40;
        E_pht_idx       = 8'h55;
        r = m_ghr;
        run_cycle(1'b1);
        e_idle();
        F_PC = 32'h200;
        #1;
        check("req24_pred", 32'(F_pred_taken), 32'd1);
        check("req24_next", F_next_pc, 32'h40);
        check("req24_ghr", 32'(dut.ghr), 32'(r));
        run_cycle(1'b1);

        // Wrong BTB target is a redirect and gets rewritten.
        e_branch(32'h180, 1'b1, 32'h304, 1'b1, 8'h10, 1'b1, 32'h300);
        #1;
        check("req25_redirect", 32'(E_redirect), 32'd1);
        check("req25_redirect_pc", E_redirect_pc, 32'h304);
        run_cycle(1'b1);
        e_idle();
        F_PC = 32'h180;
        run_cycle(1'b1);
        check("req25_rewrite", 32'(dut.u_btb.mem[6'h20].target), 32'h304);

        // Reset beats a simultaneous branch update.
        rst = 1'b1;
        e_branch(32'h100, 1'b1, 32'h180, 1'b0, 8'h40, 1'b0, 32'h0);
        run_cycle(1'b0);
        rst = 1'b0;
        e_idle();
        check_pht_all_init("req26_pht");
        check("req26_ghr", 32'(dut.ghr), 32'd0);
        F_PC = 32'h100;
        run_cycle(1'b1);

        // Randomized traffic over an aliasing PC pool.
        for (int n = 0; n < 600; n++) begin
            e_idle();
            rst  = ($urandom_range(0, 99) == 0);
            F_PC = pool[$urandom_range(0, 7)];
            r    = int'($urandom_range(0, 9));
            E_PC            = pool[$urandom_range(0, 7)];
            E_actual_target = pool[$urandom_range(0, 7)];
            E_actual_taken  = 1'($urandom);
            E_pred_taken    = 1'($urandom);
            E_pht_idx       = ($urandom_range(0, 3) != 0) ? 8'(m_idx(E_PC)) : 8'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                E_btb_hit    = m_hit(E_PC);
                E_btb_target = E_btb_hit ? m_tgt[m_bidx(E_PC)] : 32'h0;
            end else begin
                E_btb_hit    = 1'($urandom);
                E_btb_target = pool[$urandom_range(0, 7)];
            end
            E_br_valid  = (r <= 5) || (r == 8);
            E_jal_valid = (r == 6) || (r == 7) || (r == 8);
            if (E_jal_valid && r != 8) E_actual_taken = 1'b1;
            run_cycle(1'b1);
            check("rand_ghr", 32'(dut.ghr), 32'(m_ghr));
        end

        rst = 1'b0;
        e_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
